// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame states, scan-code prefixes
// and the game key codes consumed by the jump/duck logic.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus level filter for the PS/2 clock line; emits a one-cycle
// strobe when the filtered level falls.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_fall = r_fall;

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_filt <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_fall <= 1'b0;
            if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_cnt  <= '0;
                r_filt <= w_sync;
                r_fall <= r_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: deframes 11-bit frames with odd parity and
// folds E0/F0 prefixes into single key events.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_event,
    output logic       busy
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_PRE  = TW'(TIMEOUT_CYCLES - 2);

    ps2_state_e             r_state;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitcnt;
    logic                   r_parity;
    logic [TW-1:0]          r_timer;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_error;
    logic                   r_ext;
    logic                   r_rel;
    logic [7:0]             r_key_code;
    logic                   r_key_extended;
    logic                   r_key_release;
    logic                   r_key_event;
    logic                   w_fe;
    logic                   w_data;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_line (ps2_clk),
        .o_fall (w_fe)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_sync <= '1;
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign w_data = r_data_sync[SYNC_STAGES-1];

    // A falling edge always wins over the timeout check in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_parity   <= 1'b0;
            r_timer    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
            if (w_fe) begin
                r_timer <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_data) begin
                            r_state  <= DATA;
                            r_bitcnt <= '0;
                        end else begin
                            r_rx_error <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_data;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_data && (^{r_parity, r_shift})) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_error <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_timer != TMO_LAST) begin
                    r_timer <= r_timer + 1'b1;
                end
                if (r_timer == TMO_PRE) begin
                    r_state    <= IDLE;
                    r_rx_error <= 1'b1;
                end
            end
        end
    end

    // Prefix bytes only arm flags; the next plain byte carries them out as one event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext          <= 1'b0;
            r_rel          <= 1'b0;
            r_key_code     <= '0;
            r_key_extended <= 1'b0;
            r_key_release  <= 1'b0;
            r_key_event    <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            if (r_rx_error) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (r_rx_valid) begin
                if (r_rx_data == PS2_EXT_PREFIX) begin
                    r_ext <= 1'b1;
                end else if (r_rx_data == PS2_BREAK_PREFIX) begin
                    r_rel <= 1'b1;
                end else begin
                    r_key_code     <= r_rx_data;
                    r_key_extended <= r_ext;
                    r_key_release  <= r_rel;
                    r_key_event    <= 1'b1;
                    r_ext          <= 1'b0;
                    r_rel          <= 1'b0;
                end
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_error     = r_rx_error;
    assign key_code     = r_key_code;
    assign key_extended = r_key_extended;
    assign key_release  = r_key_release;
    assign key_event    = r_key_event;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: a table of frames with expected byte/key results,
// plus directed sequences for bad start, timeout and mid-frame reset.
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int TMO = 20000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_event;
    logic       busy;

    ps2_receiver #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_error     (rx_error),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_release  (key_release),
        .key_event    (key_event),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 900000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- pulse monitor ----------------
    int         n_valid = 0, n_error = 0, n_event = 0, n_both = 0;
    int         valid_cyc = 0, err_cyc = 0, ev_cyc = 0, fe_cyc = 0;
    logic [7:0] ev_code = '0;
    logic       ev_ext = 1'b0, ev_rel = 1'b0;

    always @(negedge clk) begin
        if (dut.w_fe) fe_cyc = cyc;
        if (rx_valid) begin n_valid++; valid_cyc = cyc; end
        if (rx_error) begin n_error++; err_cyc = cyc; end
        if (rx_valid && rx_error) n_both++;
        if (key_event) begin
            n_event++; ev_cyc = cyc;
            ev_code = key_code; ev_ext = key_extended; ev_rel = key_release;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input logic glitch);
        ps2_data = b;
        wait_clk(10);
        if (glitch) begin
            ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1; wait_clk(10);
        end
        ps2_clk = 1'b0;
        wait_clk(12);
        if (glitch) begin
            ps2_clk = 1'b1; wait_clk(3); ps2_clk = 1'b0;
        end
        wait_clk(8);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        wait_clk(5);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       glitch;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_rx;
        logic       exp_event;
        logic [7:0] exp_code;
        logic       exp_ext;
        logic       exp_rel;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [7:0] d, input logic bp, input logic gl, input logic ev_valid,
                           input logic ev_err, input logic [7:0] erx, input logic eev,
                           input logic [7:0] ecode, input logic eext, input logic erel);
        vec_t v;
        v.data = d; v.bad_par = bp; v.glitch = gl; v.exp_valid = ev_valid; v.exp_err = ev_err;
        v.exp_rx = erx; v.exp_event = eev; v.exp_code = ecode; v.exp_ext = eext; v.exp_rel = erel;
        vq.push_back(v);
    endtask

    int s_valid, s_error, s_event;

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_error", rx_error, 1'b0);
        check("reset_key_code", key_code, 8'h00);
        check("reset_key_flags", {key_extended, key_release, key_event}, 3'b000);
        check("reset_busy", busy, 1'b0);

        //       data              bp    gl    val   err   rx     ev    code       ext   rel
        add_vec(KEY_SPACE,        1'b0, 1'b0, 1'b1, 1'b0, 8'h29, 1'b1, KEY_SPACE, 1'b0, 1'b0);
        add_vec(PS2_BREAK_PREFIX, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_SPACE,        1'b0, 1'b0, 1'b1, 1'b0, 8'h29, 1'b1, KEY_SPACE, 1'b0, 1'b1);
        add_vec(KEY_SPACE,        1'b0, 1'b0, 1'b1, 1'b0, 8'h29, 1'b1, KEY_SPACE, 1'b0, 1'b0);
        add_vec(PS2_EXT_PREFIX,   1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(PS2_BREAK_PREFIX, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_UP,           1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, KEY_UP,    1'b1, 1'b1);
        add_vec(KEY_SPACE,        1'b1, 1'b0, 1'b0, 1'b1, 8'h75, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_DOWN,         1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 1'b1, KEY_DOWN,  1'b0, 1'b0);
        add_vec(PS2_EXT_PREFIX,   1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(PS2_EXT_PREFIX,   1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_UP,           1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, KEY_UP,    1'b1, 1'b0);
        add_vec(PS2_BREAK_PREFIX, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(PS2_BREAK_PREFIX, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_DOWN,         1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 1'b1, KEY_DOWN,  1'b0, 1'b1);
        add_vec(PS2_BREAK_PREFIX, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_SPACE,        1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_DOWN,         1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 1'b1, KEY_DOWN,  1'b0, 1'b0);
        add_vec(PS2_EXT_PREFIX,   1'b0, 1'b1, 1'b1, 1'b0, 8'hE0, 1'b0, 8'h00,    1'b0, 1'b0);
        add_vec(KEY_SPACE,        1'b0, 1'b1, 1'b1, 1'b0, 8'h29, 1'b1, KEY_SPACE, 1'b1, 1'b0);

        foreach (vq[i]) begin
            s_valid = n_valid; s_error = n_error; s_event = n_event;
            send_frame(vq[i].data, vq[i].bad_par, vq[i].glitch, 11);
            check($sformatf("v%0d_valid_cnt", i), n_valid - s_valid, vq[i].exp_valid);
            check($sformatf("v%0d_error_cnt", i), n_error - s_error, vq[i].exp_err);
            check($sformatf("v%0d_rx_data", i), rx_data, vq[i].exp_rx);
            check($sformatf("v%0d_event_cnt", i), n_event - s_event, vq[i].exp_event);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
            if (vq[i].exp_valid)
                check($sformatf("v%0d_valid_latency", i), valid_cyc - fe_cyc, 1);
            if (vq[i].exp_event) begin
                check($sformatf("v%0d_key_code", i), ev_code, vq[i].exp_code);
                check($sformatf("v%0d_key_ext", i), ev_ext, vq[i].exp_ext);
                check($sformatf("v%0d_key_rel", i), ev_rel, vq[i].exp_rel);
                check($sformatf("v%0d_event_latency", i), ev_cyc - valid_cyc, 1);
            end
        end

        // Bad start bit: a lone clock pulse with data high.
        s_valid = n_valid; s_error = n_error;
        ps2_bit(1'b1, 1'b0);
        wait_clk(5);
        check("badstart_error_cnt", n_error - s_error, 1);
        check("badstart_valid_cnt", n_valid - s_valid, 0);
        check("badstart_busy", busy, 1'b0);

        // Timeout: start + 4 data bits, then the line goes quiet.
        s_valid = n_valid; s_error = n_error;
        send_frame(KEY_UP, 1'b0, 1'b0, 5);
        check("timeout_busy_mid", busy, 1'b1);
        for (int k = 0; k < TMO + 200 && n_error == s_error; k++) wait_clk(1);
        check("timeout_error_cnt", n_error - s_error, 1);
        check("timeout_latency", err_cyc - fe_cyc, TMO);
        check("timeout_busy_after", busy, 1'b0);
        check("timeout_valid_cnt", n_valid - s_valid, 0);
        s_valid = n_valid; s_event = n_event;
        send_frame(KEY_UP, 1'b0, 1'b0, 11);
        check("post_timeout_valid_cnt", n_valid - s_valid, 1);
        check("post_timeout_rx_data", rx_data, 8'h75);
        check("post_timeout_event_cnt", n_event - s_event, 1);
        check("post_timeout_key", {ev_ext, ev_rel, ev_code}, {2'b00, 8'h75});

        // Reset during bit 5 with the ext flag armed.
        send_frame(PS2_EXT_PREFIX, 1'b0, 1'b0, 11);
        s_valid = n_valid; s_error = n_error; s_event = n_event;
        send_frame(KEY_DOWN, 1'b0, 1'b0, 6);
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        wait_clk(2);
        check("midreset_pulses", {rx_valid, rx_error, key_event}, 3'b000);
        reset = 1'b0;
        ps2_data = 1'b1;
        wait_clk(20);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_key_out", {key_extended, key_release, key_code}, 10'h000);
        check("midreset_busy", busy, 1'b0);
        check("midreset_no_pulses", (n_valid - s_valid) + (n_error - s_error) + (n_event - s_event), 0);
        send_frame(KEY_SPACE, 1'b0, 1'b0, 11);
        check("post_reset_valid_cnt", n_valid - s_valid, 1);
        check("post_reset_rx_data", rx_data, 8'h29);
        check("post_reset_event_cnt", n_event - s_event, 1);
        check("post_reset_key", {ev_ext, ev_rel, ev_code}, {2'b00, 8'h29});

        check("valid_error_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
